// File: rtl/output_collector_pkg.sv
// Shared types and helpers for the output collector: stride decode, requantization
// and the result record carried between the requant stage and the FIFO.
package output_collector_pkg;

  // Record fields are sized for the widest supported configuration
  // (OUT_WIDTH <= 32, map dimensions / channel counts <= 65536).
  localparam int RES_DATA_W = 32;
  localparam int RES_ADDR_W = 16;

  typedef enum logic [1:0] {
    STRIDE_1 = 2'd0,
    STRIDE_2 = 2'd1,
    STRIDE_4 = 2'd2
  } stride_mode_e;

  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic [RES_ADDR_W-1:0] x;
    logic [RES_ADDR_W-1:0] y;
    logic [RES_ADDR_W-1:0] ch;
  } result_t;

  // Round half up, arithmetic shift, optional ReLU, saturate to a signed ow-bit range.
  function automatic longint requant(longint acc, logic [4:0] sh, logic relu, int ow);
    longint t, hi, lo;
    t = acc;
    if (sh != 5'd0) t = t + (longint'(1) << (sh - 5'd1));
    t = t >>> sh;
    if (relu && t < 0) t = 0;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (t > hi) t = hi;
    else if (t < lo) t = lo;
    return t;
  endfunction

  // Results per layer; the reserved mode encoding behaves as stride 4.
  function automatic logic [31:0] layer_total(int w, int h, int ch, logic [1:0] mode);
    stride_mode_e m;
    int s;
    m = (mode == 2'd3) ? STRIDE_4 : stride_mode_e'(mode);
    case (m)
      STRIDE_1: s = 0;
      STRIDE_2: s = 1;
      default:  s = 2;
    endcase
    return 32'((w >> s) * (h >> s) * ch);
  endfunction

endpackage

// File: rtl/output_collector_if.sv
// Result-stream bundle: pixel results in from the controller, requantized words out
// to the output memory. master = collector side, slave = controller/memory side.
interface output_collector_if #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int CH_W      = 6
);
  logic                 in_valid;
  logic [ACC_WIDTH-1:0] in_data;
  logic [X_W-1:0]       in_x;
  logic [Y_W-1:0]       in_y;
  logic [CH_W-1:0]      in_ch;
  logic                 stall;

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [X_W-1:0]       out_x;
  logic [Y_W-1:0]       out_y;
  logic [CH_W-1:0]      out_ch;

  modport master (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output stall, out_valid, out_data, out_x, out_y, out_ch
  );

  modport slave (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  stall, out_valid, out_data, out_x, out_y, out_ch
  );
endinterface

// File: rtl/output_collector_fifo.sv
// First-word-fall-through FIFO; a push while full is taken only if a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/output_collector.sv
// Captures finished output pixels, requantizes them, buffers them in a FIFO and
// streams them to the output memory with stall backpressure to the controller.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int ACC_WIDTH          = 32,
  parameter int OUT_WIDTH          = 16,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    start,
  input  logic [1:0]              conv_stride_mode,
  input  logic                    relu_en,
  input  logic [4:0]              shift,
  output_collector_if.master      bus,
  output logic                    overflow,
  output logic                    done,
  output logic [31:0]             count_out
);
  localparam int XW     = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW     = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW     = $clog2(OUTPUT_NB_CHANNELS);
  localparam int FW     = OUT_WIDTH + XW + YW + CW;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STAGES = 1;

  logic [4:0]           shift_q;
  logic                 relu_q;
  logic [31:0]          expected_q;

  // vld_pipe[0]: capture register, vld_pipe[STAGES]: requant register (FIFO push)
  logic [STAGES:0]      vld_pipe;
  logic                 in_accept;
  logic [ACC_WIDTH-1:0] cap_data;
  logic [XW-1:0]        cap_x;
  logic [YW-1:0]        cap_y;
  logic [CW-1:0]        cap_ch;
  result_t              req_q, req_d;
  logic signed [63:0]   rq;

  logic                 push, pop, fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_din, fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       occupancy;
  logic                 unused_req;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      shift_q    <= '0;
      relu_q     <= 1'b0;
      expected_q <= '0;
    end else if (start) begin
      shift_q    <= shift;
      relu_q     <= relu_en;
      expected_q <= layer_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                                OUTPUT_NB_CHANNELS, conv_stride_mode);
    end
  end

  // A result arriving with start belongs to the old layer and is dropped.
  assign in_accept = bus.in_valid & ~start;

  assign rq = requant(longint'($signed(cap_data)), shift_q, relu_q, OUT_WIDTH);

  always_comb begin
    req_d      = '0;
    req_d.data = RES_DATA_W'(rq[OUT_WIDTH-1:0]);
    req_d.x    = RES_ADDR_W'(cap_x);
    req_d.y    = RES_ADDR_W'(cap_y);
    req_d.ch   = RES_ADDR_W'(cap_ch);
  end

  always_ff @(posedge clk) begin
    if (rst_in || start) begin
      vld_pipe <= '0;
      cap_data <= '0;
      cap_x    <= '0;
      cap_y    <= '0;
      cap_ch   <= '0;
      req_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_accept};
      if (in_accept) begin
        cap_data <= bus.in_data;
        cap_x    <= bus.in_x;
        cap_y    <= bus.in_y;
        cap_ch   <= bus.in_ch;
      end
      if (vld_pipe[0]) req_q <= req_d;
    end
  end

  assign push     = vld_pipe[STAGES];
  assign pop      = bus.out_valid & bus.out_ready;
  assign fifo_din = {req_q.data[OUT_WIDTH-1:0], req_q.x[XW-1:0],
                     req_q.y[YW-1:0], req_q.ch[CW-1:0]};
  assign unused_req = ^req_q;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst_in),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = ~fifo_empty;
  assign {bus.out_data, bus.out_x, bus.out_y, bus.out_ch} = fifo_dout;

  // Both pipeline registers count as in flight so a one-cycle-late controller still fits.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(vld_pipe[0]) + (CNT_W+1)'(vld_pipe[1]);
  assign bus.stall = (occupancy >= (CNT_W+1)'(FIFO_DEPTH - 2));

  always_ff @(posedge clk) begin
    if (rst_in || start) begin
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pop) count_out <= count_out + 32'd1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign done = pop & ~start & ~rst_in & ((count_out + 32'd1) == expected_q);

endmodule
